// File: rtl/rgb_cmd_pkg.sv
// -----------------------------------------------------------------------------
// rgb_cmd_pkg
// Shared definitions for the RGB command sequencer: ASCII command byte values,
// sequencer state encoding, auto colour-walk index and shadow Lit bit positions.
// No ports (package).
// -----------------------------------------------------------------------------
package rgb_cmd_pkg;

    // Command bytes understood by the RGB toggle FSM and by the sequencer
    localparam logic [7:0] CMD_R    = 8'd82;  // 'R' toggle red
    localparam logic [7:0] CMD_G    = 8'd71;  // 'G' toggle green
    localparam logic [7:0] CMD_B    = 8'd66;  // 'B' toggle blue
    localparam logic [7:0] CMD_A    = 8'd65;  // 'A' enter auto colour-walk
    localparam logic [7:0] CMD_M    = 8'd77;  // 'M' back to manual
    localparam logic [7:0] CMD_C    = 8'd67;  // 'C' clear all lit colours
    localparam logic [7:0] CMD_IDLE = 8'd0;   // nothing driven to the FSM

    // Shadow Lit bit positions
    localparam int LIT_R = 2;
    localparam int LIT_G = 1;
    localparam int LIT_B = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        CLR   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        AUTO_R = 2'd0,
        AUTO_G = 2'd1,
        AUTO_B = 2'd2
    } auto_idx_t;

    // Lit bit touched by a colour command (zero for anything else)
    function automatic logic [2:0] lit_mask(input logic [7:0] cmd);
        logic [2:0] mask;
        mask = 3'b000;
        case (cmd)
            CMD_R:   mask[LIT_R] = 1'b1;
            CMD_G:   mask[LIT_G] = 1'b1;
            CMD_B:   mask[LIT_B] = 1'b1;
            default: mask = 3'b000;
        endcase
        return mask;
    endfunction

    function automatic logic [7:0] auto_cmd(input auto_idx_t idx);
        case (idx)
            AUTO_G:  return CMD_G;
            AUTO_B:  return CMD_B;
            default: return CMD_R;
        endcase
    endfunction

    function automatic auto_idx_t auto_next(input auto_idx_t idx);
        case (idx)
            AUTO_R:  return AUTO_G;
            AUTO_G:  return AUTO_B;
            default: return AUTO_R;
        endcase
    endfunction

endpackage

// File: rtl/rgb_cmd_fifo.sv
// -----------------------------------------------------------------------------
// rgb_cmd_fifo
// Single-clock first-word-fall-through byte FIFO buffering host bytes.
// Ports:
//   Clock, Reset  - clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_din - write strobe and byte (ignored when full)
//   i_pop         - consume the head entry (ignored when empty)
//   o_full        - FIFO_DEPTH entries held
//   o_empty       - no entries held
//   o_dout        - head entry, valid whenever o_empty is low
// -----------------------------------------------------------------------------
module rgb_cmd_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       i_push,
    input  logic [7:0] i_din,
    input  logic       i_pop,
    output logic       o_full,
    output logic       o_empty,
    output logic [7:0] o_dout
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  r_mem [FIFO_DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_wr_en;
    logic        w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;

    // NOTE: storage has no reset; only the pointers define what is valid,
    // so clearing the array would just cost reset fan-out.
    always_ff @(posedge Clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/rgb_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// rgb_cmd_sequencer
// Front end for the 8-state RGB toggle FSM. Buffers host bytes, decodes
// control commands, runs an optional auto colour-walk and emits each colour
// command as a one-cycle Cmd pulse followed by idle gap cycles. Keeps a shadow
// copy of the lit colours.
// Ports:
//   Clock, Reset      - clock, synchronous active-high reset
//   RxData, RxValid   - byte from the UART receiver
//   RxReady           - high while the host FIFO is not full
//   Cmd               - command byte to the RGB FSM, 0x00 when idle
//   Lit               - shadow lit state [2]=R [1]=G [0]=B
//   AutoMode          - auto colour-walk active
//   Busy              - sequencer away from IDLE (registered, one cycle late)
//   Dropped           - one-cycle pulse when an unknown byte is discarded
// -----------------------------------------------------------------------------
module rgb_cmd_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TICK_CYCLES = 50000000,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] RxData,
    input  logic       RxValid,
    output logic       RxReady,
    output logic [7:0] Cmd,
    output logic [2:0] Lit,
    output logic       AutoMode,
    output logic       Busy,
    output logic       Dropped
);

    import rgb_cmd_pkg::*;

    localparam int TW = $clog2(TICK_CYCLES);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    state_t          r_state;
    logic [7:0]      r_cmd;
    logic [7:0]      r_issue_cmd;   // colour command waiting in ISSUE
    logic [2:0]      r_lit;
    logic            r_auto;
    logic            r_busy;
    logic            r_dropped;
    logic            r_ret_clr;     // GAP returns to CLR instead of IDLE
    logic [GW-1:0]   r_gap_cnt;
    logic [TW-1:0]   r_tick_cnt;
    logic            r_tick_pend;
    auto_idx_t       r_auto_idx;

    logic            w_full;
    logic            w_empty;
    logic [7:0]      w_head;
    logic            w_push;
    logic            w_pop;
    logic            w_dispatch;
    logic            w_mode_pop;
    logic            w_tick;

    assign w_push  = RxValid && !w_full;
    assign RxReady = !w_full;

    // IDLE's work is also done in the last GAP cycle when returning to IDLE,
    // so back-to-back commands land exactly GAP_CYCLES zero cycles apart
    // (the remaining zero cycle is ISSUE itself).
    assign w_dispatch = (r_state == IDLE) ||
                        ((r_state == GAP) && (r_gap_cnt == GAP_LAST) && !r_ret_clr);
    assign w_pop      = w_dispatch && !w_empty;
    assign w_mode_pop = w_pop && ((w_head == CMD_A) || (w_head == CMD_M));
    assign w_tick     = r_auto && (r_tick_cnt == TICK_LAST);

    rgb_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_push  (w_push),
        .i_din   (RxData),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_dout  (w_head)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_cmd       <= CMD_IDLE;
            r_issue_cmd <= CMD_IDLE;
            r_lit       <= 3'b000;
            r_auto      <= 1'b0;
            r_busy      <= 1'b0;
            r_dropped   <= 1'b0;
            r_ret_clr   <= 1'b0;
            r_gap_cnt   <= '0;
            r_tick_cnt  <= '0;
            r_tick_pend <= 1'b0;
            r_auto_idx  <= AUTO_R;
        end else begin
            r_cmd     <= CMD_IDLE;
            r_dropped <= 1'b0;
            r_busy    <= (r_state != IDLE);

            case (r_state)
                ISSUE: begin
                    r_cmd     <= r_issue_cmd;
                    r_lit     <= r_lit ^ lit_mask(r_issue_cmd);
                    r_gap_cnt <= '0;
                    r_state   <= GAP;
                end
                GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= r_ret_clr ? CLR : IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                CLR: begin
                    // Issued bits come back cleared, so the first lit bit in
                    // R,G,B order is always the next one to switch off.
                    r_ret_clr <= 1'b1;
                    if (r_lit[LIT_R]) begin
                        r_issue_cmd <= CMD_R;
                        r_state     <= ISSUE;
                    end else if (r_lit[LIT_G]) begin
                        r_issue_cmd <= CMD_G;
                        r_state     <= ISSUE;
                    end else if (r_lit[LIT_B]) begin
                        r_issue_cmd <= CMD_B;
                        r_state     <= ISSUE;
                    end else begin
                        r_ret_clr <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: ;  // IDLE: handled by the dispatch below
            endcase

            // Dispatch overrides the GAP->IDLE return above; FIFO beats tick
            if (w_dispatch) begin
                if (!w_empty) begin
                    case (w_head)
                        CMD_R, CMD_G, CMD_B: begin
                            r_issue_cmd <= w_head;
                            r_ret_clr   <= 1'b0;
                            r_state     <= ISSUE;
                        end
                        CMD_A: begin
                            r_auto      <= 1'b1;
                            r_tick_cnt  <= '0;
                            r_tick_pend <= 1'b0;
                            r_auto_idx  <= AUTO_R;
                        end
                        CMD_M: begin
                            r_auto      <= 1'b0;
                            r_tick_pend <= 1'b0;
                        end
                        CMD_C: begin
                            r_state <= CLR;
                        end
                        default: begin
                            r_dropped <= 1'b1;
                        end
                    endcase
                end else if (r_tick_pend) begin
                    r_issue_cmd <= auto_cmd(r_auto_idx);
                    r_auto_idx  <= auto_next(r_auto_idx);
                    r_tick_pend <= 1'b0;
                    r_ret_clr   <= 1'b0;
                    r_state     <= ISSUE;
                end
            end

            // Placed after dispatch so a tick landing on the serve edge stays
            // pending; skipped when 'A'/'M' rewrite the auto state this edge.
            if (r_auto && !w_mode_pop) begin
                if (w_tick) begin
                    r_tick_cnt  <= '0;
                    r_tick_pend <= 1'b1;
                end else begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                end
            end
        end
    end

    assign Cmd      = r_cmd;
    assign Lit      = r_lit;
    assign AutoMode = r_auto;
    assign Busy     = r_busy;
    assign Dropped  = r_dropped;

endmodule

// File: tb/tb_rgb_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rgb_cmd_sequencer
// Directed bench for rgb_cmd_sequencer (FIFO_DEPTH=4, TICK_CYCLES=16,
// GAP_CYCLES=2). Each scenario task drives bytes and compares outputs inline
// against hand-computed values. A negedge monitor logs every nonzero Cmd with
// its cycle number and the Lit value seen alongside it.
// -----------------------------------------------------------------------------
module tb_rgb_cmd_sequencer;

    import rgb_cmd_pkg::*;

    localparam int FIFO_DEPTH  = 4;
    localparam int TICK_CYCLES = 16;
    localparam int GAP_CYCLES  = 2;

    logic       Clock   = 1'b0;
    logic       Reset   = 1'b1;
    logic [7:0] RxData  = 8'd0;
    logic       RxValid = 1'b0;
    logic       RxReady;
    logic [7:0] Cmd;
    logic [2:0] Lit;
    logic       AutoMode;
    logic       Busy;
    logic       Dropped;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         cyc;
        logic [7:0] cmd;
        logic [2:0] lit;
    } pulse_t;

    pulse_t plog[$];
    int     cyc       = 0;
    int     drop_cnt  = 0;
    bit     saw_full  = 1'b0;

    rgb_cmd_sequencer #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .TICK_CYCLES (TICK_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .RxData   (RxData),
        .RxValid  (RxValid),
        .RxReady  (RxReady),
        .Cmd      (Cmd),
        .Lit      (Lit),
        .AutoMode (AutoMode),
        .Busy     (Busy),
        .Dropped  (Dropped)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc++;

    always @(negedge Clock) begin
        if (!Reset) begin
            if (Cmd != CMD_IDLE) plog.push_back('{cyc, Cmd, Lit});
            if (Dropped) drop_cnt++;
            if (!RxReady) saw_full = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Leaves time at a negedge with Reset released and bench logs cleared
    task automatic do_reset();
        Reset   = 1'b1;
        RxValid = 1'b0;
        RxData  = 8'd0;
        repeat (3) @(negedge Clock);
        Reset    = 1'b0;
        plog.delete();
        drop_cnt = 0;
        saw_full = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge
    task automatic send(input logic [7:0] b);
        bit   ok;
        logic rdy;
        ok      = 1'b0;
        RxData  = b;
        RxValid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            rdy = RxReady;
            @(negedge Clock);
            ok = rdy;
        end
        RxValid = 1'b0;
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL send_accept: byte %0d accepted=%0b required 1", b, ok);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({Cmd, Lit, AutoMode, Busy, Dropped, RxReady} !== {8'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_values: Cmd=%0d Lit=%b Auto=%b Busy=%b Drop=%b Rdy=%b required 0 000 0 0 0 1",
                     Cmd, Lit, AutoMode, Busy, Dropped, RxReady);
        end
    endtask

    // Byte accepted at edge t0: Cmd=82 in cycle t0+2 only, Busy t0+2..t0+4
    task automatic test_single();
        logic [7:0] exp_cmd  [5];
        logic       exp_busy [5];
        logic [2:0] exp_lit  [5];
        do_reset();
        exp_cmd  = '{8'd0, 8'd82, 8'd0, 8'd0, 8'd0};
        exp_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_lit  = '{3'b000, 3'b100, 3'b100, 3'b100, 3'b100};
        send(CMD_R);
        for (int k = 0; k < 5; k++) begin
            @(negedge Clock);
            n_cmp++;
            if ({Cmd, Busy, Lit} !== {exp_cmd[k], exp_busy[k], exp_lit[k]}) begin
                n_bad++;
                $display("FAIL single_t%0d: Cmd=%0d Busy=%b Lit=%b required %0d %b %b",
                         k + 1, Cmd, Busy, Lit, exp_cmd[k], exp_busy[k], exp_lit[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [4];
        seq = '{CMD_R, CMD_G, CMD_B, CMD_G};
        do_reset();
        for (int k = 0; k < 4; k++) send(seq[k]);
        wait_cycles(20);
        n_cmp++;
        if (plog.size() !== 4) begin
            n_bad++;
            $display("FAIL b2b_count: pulses=%0d required 4", plog.size());
        end
        for (int k = 0; k < 4 && k < plog.size(); k++) begin
            n_cmp++;
            if (plog[k].cmd !== seq[k]) begin
                n_bad++;
                $display("FAIL b2b_cmd%0d: Cmd=%0d required %0d", k, plog[k].cmd, seq[k]);
            end
            if (k > 0) begin
                n_cmp++;
                if (plog[k].cyc - plog[k-1].cyc !== 3) begin
                    n_bad++;
                    $display("FAIL b2b_spacing%0d: spacing=%0d required 3", k, plog[k].cyc - plog[k-1].cyc);
                end
            end
        end
        n_cmp++;
        if ({Lit, saw_full} !== {3'b101, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_final: Lit=%b sawNotReady=%b required 101 0", Lit, saw_full);
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] seq [6];
        seq = '{CMD_R, CMD_G, CMD_B, CMD_G, CMD_R, CMD_B};
        do_reset();
        for (int k = 0; k < 6; k++) send(seq[k]);
        wait_cycles(30);
        n_cmp++;
        if (saw_full !== 1'b1) begin
            n_bad++;
            $display("FAIL full_ready_low: sawNotReady=%b required 1", saw_full);
        end
        n_cmp++;
        if (plog.size() !== 6) begin
            n_bad++;
            $display("FAIL full_count: pulses=%0d required 6", plog.size());
        end
        for (int k = 0; k < 6 && k < plog.size(); k++) begin
            n_cmp++;
            if (plog[k].cmd !== seq[k]) begin
                n_bad++;
                $display("FAIL full_order%0d: Cmd=%0d required %0d", k, plog[k].cmd, seq[k]);
            end
        end
        n_cmp++;
        if (Lit !== 3'b000) begin
            n_bad++;
            $display("FAIL full_lit: Lit=%b required 000", Lit);
        end
    endtask

    task automatic test_auto();
        logic [7:0] exp_cmd [4];
        logic [2:0] exp_lit [4];
        exp_cmd = '{CMD_R, CMD_G, CMD_B, CMD_R};
        exp_lit = '{3'b100, 3'b110, 3'b111, 3'b011};
        do_reset();
        send(CMD_A);
        for (int i = 0; i < 120 && plog.size() < 4; i++) @(negedge Clock);
        n_cmp++;
        if (plog.size() < 4) begin
            n_bad++;
            $display("FAIL auto_timeout: pulses=%0d required 4", plog.size());
        end
        send(CMD_M);
        wait_cycles(64);
        n_cmp++;
        if ({plog.size(), AutoMode} !== {32'd4, 1'b0}) begin
            n_bad++;
            $display("FAIL auto_stop: pulses=%0d Auto=%b required 4 0", plog.size(), AutoMode);
        end
        for (int k = 0; k < 4 && k < plog.size(); k++) begin
            n_cmp++;
            if ({plog[k].cmd, plog[k].lit} !== {exp_cmd[k], exp_lit[k]}) begin
                n_bad++;
                $display("FAIL auto_walk%0d: Cmd=%0d Lit=%b required %0d %b",
                         k, plog[k].cmd, plog[k].lit, exp_cmd[k], exp_lit[k]);
            end
            if (k > 0) begin
                n_cmp++;
                if (plog[k].cyc - plog[k-1].cyc !== TICK_CYCLES) begin
                    n_bad++;
                    $display("FAIL auto_spacing%0d: spacing=%0d required %0d",
                             k, plog[k].cyc - plog[k-1].cyc, TICK_CYCLES);
                end
            end
        end
    endtask

    task automatic test_clear();
        int busy_cnt;
        do_reset();
        send(CMD_R);
        send(CMD_B);
        wait_cycles(10);
        n_cmp++;
        if (Lit !== 3'b101) begin
            n_bad++;
            $display("FAIL clr_setup: Lit=%b required 101", Lit);
        end
        plog.delete();
        send(CMD_C);
        wait_cycles(20);
        n_cmp++;
        if (plog.size() !== 2) begin
            n_bad++;
            $display("FAIL clr_count: pulses=%0d required 2", plog.size());
        end else begin
            n_cmp++;
            if ({plog[0].cmd, plog[1].cmd} !== {CMD_R, CMD_B}) begin
                n_bad++;
                $display("FAIL clr_order: Cmd=%0d,%0d required 82,66", plog[0].cmd, plog[1].cmd);
            end
        end
        n_cmp++;
        if (Lit !== 3'b000) begin
            n_bad++;
            $display("FAIL clr_lit: Lit=%b required 000", Lit);
        end
        plog.delete();
        busy_cnt = 0;
        send(CMD_C);
        if (Busy) busy_cnt++;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            if (Busy) busy_cnt++;
        end
        n_cmp++;
        if (!(busy_cnt inside {[1:2]}) || plog.size() != 0) begin
            n_bad++;
            $display("FAIL clr_empty: busyCycles=%0d pulses=%0d required 1..2 and 0", busy_cnt, plog.size());
        end
    endtask

    task automatic test_drop();
        do_reset();
        send(CMD_A);
        send(8'h58);
        wait_cycles(6);
        n_cmp++;
        if ({AutoMode, drop_cnt, plog.size()} !== {1'b1, 32'd1, 32'd0}) begin
            n_bad++;
            $display("FAIL drop: Auto=%b drops=%0d pulses=%0d required 1 1 0", AutoMode, drop_cnt, plog.size());
        end
    endtask

    task automatic test_reset_in_gap();
        bit seen;
        do_reset();
        send(CMD_A);
        send(CMD_R);
        send(CMD_G);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (Cmd == CMD_R) seen = 1'b1;
            else @(negedge Clock);
        end
        n_cmp++;
        if ({seen, AutoMode} !== 2'b11) begin
            n_bad++;
            $display("FAIL rst_gap_setup: seenPulse=%b Auto=%b required 1 1", seen, AutoMode);
        end
        Reset = 1'b1;
        @(negedge Clock);
        n_cmp++;
        if ({Cmd, Lit, AutoMode, RxReady, Busy} !== {8'd0, 3'b000, 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_gap: Cmd=%0d Lit=%b Auto=%b Rdy=%b Busy=%b required 0 000 0 1 0",
                     Cmd, Lit, AutoMode, RxReady, Busy);
        end
        Reset = 1'b0;
        plog.delete();
        wait_cycles(40);
        n_cmp++;
        if (plog.size() !== 0) begin
            n_bad++;
            $display("FAIL rst_gap_flush: pulses=%0d required 0", plog.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_auto();
        test_clear();
        test_drop();
        test_reset_in_gap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
